// File: rtl/lsu_pkg.sv
// Shared constants for the LSU serializer: FSM state encoding, default sizes
// and the lane-index width helper.
package lsu_pkg;

    localparam int LANES_DEF  = 4;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // A single-lane build still needs a 1-bit index register.
    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int IDX_W = idx_width(LANES_DEF);

endpackage

// File: rtl/lsu_lane_sel.sv
// Picks the current lane's address/data/enable out of the latched flat vectors.
// With LSU_SKIP_MASKED_EN it also finds the first and next enabled lanes.
module lsu_lane_sel
    import lsu_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IW     = idx_width(LANES)
) (
    input  logic [IW-1:0]           idx,
    input  logic [LANES-1:0]        mask,
    input  logic [LANES*ADDR_W-1:0] addr_vec,
    input  logic [LANES*DATA_W-1:0] wdata_vec,
    output logic [ADDR_W-1:0]       lane_addr,
    output logic [DATA_W-1:0]       lane_wdata,
    output logic                    lane_en
`ifdef LSU_SKIP_MASKED_EN
    ,
    input  logic [LANES-1:0]        scan_mask,
    output logic [IW-1:0]           first_idx,
    output logic                    first_valid,
    output logic [IW-1:0]           next_idx,
    output logic                    next_valid
`endif
);

    assign lane_addr  = addr_vec[int'(idx)*ADDR_W +: ADDR_W];
    assign lane_wdata = wdata_vec[int'(idx)*DATA_W +: DATA_W];
    assign lane_en    = mask[idx];

`ifdef LSU_SKIP_MASKED_EN
    // Scanning downwards lets the lowest qualifying lane overwrite the result.
    always_comb begin
        first_idx   = '0;
        first_valid = 1'b0;
        next_idx    = '0;
        next_valid  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (scan_mask[i]) begin
                first_idx   = IW'(i);
                first_valid = 1'b1;
            end
            if (mask[i] && (i > int'(idx))) begin
                next_idx   = IW'(i);
                next_valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/lsu_serializer.sv
// Vector load/store front end: one memory access per lane per cycle, then a
// single response pulse. Define LSU_SKIP_MASKED_EN to skip disabled lanes.
module lsu_serializer
    import lsu_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [LANES-1:0]        req_mask,
    input  logic [LANES*ADDR_W-1:0] req_addr,
    input  logic [LANES*DATA_W-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [LANES*DATA_W-1:0] resp_rdata,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int IW = idx_width(LANES);

    logic [1:0]              state;
    logic [IW-1:0]           idx;
    logic                    lat_write;
    logic [LANES-1:0]        lat_mask;
    logic [LANES*ADDR_W-1:0] lat_addr;
    logic [LANES*DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0]       lane_addr;
    logic [DATA_W-1:0]       lane_wdata;
    logic                    lane_en;
`ifdef LSU_SKIP_MASKED_EN
    logic [IW-1:0]           first_idx;
    logic                    first_valid;
    logic [IW-1:0]           next_idx;
    logic                    next_valid;
`endif

    lsu_lane_sel #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .IW    (IW)
    ) u_sel (
        .idx        (idx),
        .mask       (lat_mask),
        .addr_vec   (lat_addr),
        .wdata_vec  (lat_wdata),
        .lane_addr  (lane_addr),
        .lane_wdata (lane_wdata),
        .lane_en    (lane_en)
`ifdef LSU_SKIP_MASKED_EN
        ,
        .scan_mask  (req_mask),
        .first_idx  (first_idx),
        .first_valid(first_valid),
        .next_idx   (next_idx),
        .next_valid (next_valid)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            lat_write  <= 1'b0;
            lat_mask   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_mask   <= req_mask;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        resp_rdata <= '0;
`ifdef LSU_SKIP_MASKED_EN
                        idx   <= first_idx;
                        state <= first_valid ? ACCESS : RESP;
`else
                        idx   <= '0;
                        state <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    // Disabled lanes keep the zero written at accept time.
                    if (!lat_write && lane_en)
                        resp_rdata[int'(idx)*DATA_W +: DATA_W] <= mem_rdata;
`ifdef LSU_SKIP_MASKED_EN
                    if (next_valid)
                        idx <= next_idx;
                    else
                        state <= RESP;
`else
                    if (idx == IW'(LANES - 1))
                        state <= RESP;
                    else
                        idx <= idx + IW'(1);
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Gating with reset keeps a reset edge from committing a half-finished store.
    assign mem_write = (state == ACCESS) && lat_write && lane_en && !reset;
    assign mem_addr  = (state == ACCESS) ? lane_addr  : '0;
    assign mem_wdata = (state == ACCESS) ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_serializer.sv
// Self-checking bench for lsu_serializer with a 64 x 16 memory model and a
// lane-by-lane reference model of loads, stores and timing.
module tb_lsu_serializer;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int LOG_W  = 8 * 40;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [LANES-1:0]        req_mask;
    logic [LANES*ADDR_W-1:0] req_addr;
    logic [LANES*DATA_W-1:0] req_wdata;
    logic                    resp_valid;
    logic [LANES*DATA_W-1:0] resp_rdata;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    logic [15:0] mem [64] = '{default: 16'h0};
    logic [15:0] ref_mem [64] = '{default: 16'h0};

    int checks   = 0;
    int failures = 0;

    lsu_serializer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_mask  (req_mask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int visited(input logic [LANES-1:0] m);
`ifdef LSU_SKIP_MASKED_EN
        return $countones(m);
`else
        return LANES;
`endif
    endfunction

    // Reference: walk lanes in order, one slot per visited lane.
    task automatic model_request(input logic w, input logic [LANES-1:0] m,
                                 input logic [LANES*ADDR_W-1:0] a,
                                 input logic [LANES*DATA_W-1:0] d,
                                 output logic [LANES*DATA_W-1:0] exp_rd,
                                 output logic [LOG_W-1:0] exp_log, output int exp_cnt);
        int slot = 0;
        logic [15:0] la, ld;
        exp_rd = '0; exp_log = '0; exp_cnt = 0;
        for (int i = 0; i < LANES; i++) begin
            la = a[i*ADDR_W +: ADDR_W];
            ld = d[i*DATA_W +: DATA_W];
`ifdef LSU_SKIP_MASKED_EN
            if (!m[i]) continue;
`endif
            if (m[i] && w) begin
                ref_mem[la % 64] = ld;
                exp_log = {exp_log[LOG_W-41:0], 8'(slot), la, ld};
                exp_cnt++;
            end
            if (m[i] && !w) exp_rd[i*DATA_W +: DATA_W] = ref_mem[la % 64];
            slot++;
        end
    endtask

    task automatic do_request(input logic w, input logic [LANES-1:0] m,
                              input logic [LANES*ADDR_W-1:0] a,
                              input logic [LANES*DATA_W-1:0] d,
                              output logic [LANES*DATA_W-1:0] rd, output int lat,
                              output logic [LOG_W-1:0] wlog, output int wcnt,
                              output logic ready_after, output logic pulse_after,
                              output logic timeout);
        int n = 0;
        rd = '0; lat = -1; wlog = '0; wcnt = 0; timeout = 1'b0;
        ready_after = 1'b0; pulse_after = 1'b1;
        req_valid = 1'b1; req_write = w; req_mask = m; req_addr = a; req_wdata = d;
        while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
        if (req_ready !== 1'b1) begin timeout = 1'b1; req_valid = 1'b0; return; end
        step();
        req_valid = 1'b0; req_write = 1'($urandom); req_mask = LANES'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        for (int k = 0; k < 30; k++) begin
            if (mem_write === 1'b1) begin
                wlog = {wlog[LOG_W-41:0], 8'(k), mem_addr, mem_wdata};
                wcnt++;
            end
            if (resp_valid === 1'b1) begin lat = k; rd = resp_rdata; break; end
            step();
        end
        if (lat < 0) begin timeout = 1'b1; return; end
        step();
        ready_after = req_ready;
        pulse_after = resp_valid;
    endtask

    logic [LANES*DATA_W-1:0] rd, exp_rd;
    logic [LOG_W-1:0]        wlog, exp_log;
    int                      lat, wcnt, exp_cnt;
    logic                    rdy_a, pls_a, tmo;

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_mask = '0; req_addr = '0; req_wdata = '0;
        step(); step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b expected 1", req_ready); end
            checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_resp: got %b expected 0", resp_valid); end
            checks++; if (mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("[TB] FAIL rst_mem: got %b/%h/%h expected 0/0/0", mem_write, mem_addr, mem_wdata); end
            checks++; if (resp_rdata !== '0) begin failures++; $display("[TB] FAIL rst_rdata: got %h expected 0", resp_rdata); end
            step();
        end
    endtask

    task automatic test_store_load();
        logic [LANES*ADDR_W-1:0] a = {16'd3, 16'd2, 16'd1, 16'd0};
        logic [LANES*DATA_W-1:0] d = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        model_request(1'b1, 4'b1111, a, d, exp_rd, exp_log, exp_cnt);
        do_request(1'b1, 4'b1111, a, d, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (tmo) begin failures++; $display("[TB] FAIL sl_st_timeout: got timeout expected response"); end
        checks++; if (lat != visited(4'b1111)) begin failures++; $display("[TB] FAIL sl_st_lat: got %0d expected %0d", lat, visited(4'b1111)); end
        checks++; if (wcnt != exp_cnt || wlog !== exp_log) begin failures++; $display("[TB] FAIL sl_st_writes: got %0d writes %h expected %0d %h", wcnt, wlog[159:0], exp_cnt, exp_log[159:0]); end
        checks++; if (rd !== '0) begin failures++; $display("[TB] FAIL sl_st_rdata: got %h expected 0", rd); end
        checks++; if (rdy_a !== 1'b1 || pls_a !== 1'b0) begin failures++; $display("[TB] FAIL sl_st_after: got ready=%b resp=%b expected 1/0", rdy_a, pls_a); end
        model_request(1'b0, 4'b1111, a, d, exp_rd, exp_log, exp_cnt);
        do_request(1'b0, 4'b1111, a, '0, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (rd !== 64'hDDDD_CCCC_BBBB_AAAA || rd !== exp_rd) begin failures++; $display("[TB] FAIL sl_ld_rdata: got %h expected %h", rd, exp_rd); end
        checks++; if (wcnt != 0) begin failures++; $display("[TB] FAIL sl_ld_nowrite: got %0d writes expected 0", wcnt); end
    endtask

    task automatic test_masked_load();
        logic [LANES*ADDR_W-1:0] a = {16'd11, 16'd10, 16'd9, 16'd8};
        logic [LANES*DATA_W-1:0] d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        model_request(1'b1, 4'b1111, a, d, exp_rd, exp_log, exp_cnt);
        do_request(1'b1, 4'b1111, a, d, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (tmo || wlog !== exp_log) begin failures++; $display("[TB] FAIL ml_preload: got %h expected %h", wlog[159:0], exp_log[159:0]); end
        model_request(1'b0, 4'b0101, a, '0, exp_rd, exp_log, exp_cnt);
        do_request(1'b0, 4'b0101, a, '0, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (rd !== 64'h0000_3333_0000_1111 || rd !== exp_rd) begin failures++; $display("[TB] FAIL ml_rdata: got %h expected %h", rd, exp_rd); end
        checks++; if (wcnt != 0) begin failures++; $display("[TB] FAIL ml_nowrite: got %0d writes expected 0", wcnt); end
        checks++; if (lat != visited(4'b0101)) begin failures++; $display("[TB] FAIL ml_lat: got %0d expected %0d", lat, visited(4'b0101)); end
    endtask

    task automatic test_same_addr();
        logic [LANES*ADDR_W-1:0] a = {4{16'd5}};
        logic [LANES*DATA_W-1:0] d = {16'd4, 16'd3, 16'd2, 16'd1};
        model_request(1'b1, 4'b1111, a, d, exp_rd, exp_log, exp_cnt);
        do_request(1'b1, 4'b1111, a, d, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (tmo || wcnt != exp_cnt || wlog !== exp_log) begin failures++; $display("[TB] FAIL sa_writes: got %0d %h expected %0d %h", wcnt, wlog[159:0], exp_cnt, exp_log[159:0]); end
        do_request(1'b0, 4'b0001, a, '0, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (rd[15:0] !== 16'h0004 || rd[63:16] !== '0) begin failures++; $display("[TB] FAIL sa_winner: got %h expected 0004", rd); end
`ifdef LSU_SKIP_MASKED_EN
        model_request(1'b1, 4'b0000, a, d, exp_rd, exp_log, exp_cnt);
        do_request(1'b1, 4'b0000, a, d, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (lat != 0 || wcnt != 0) begin failures++; $display("[TB] FAIL sa_skip_zero: got lat=%0d writes=%0d expected 0/0", lat, wcnt); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [LANES*ADDR_W-1:0] a = {16'd23, 16'd22, 16'd21, 16'd20};
        logic [LANES*DATA_W-1:0] d;
        logic seen = 1'b0;
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = 16'($urandom_range(1, 16'hFFFF));
        req_valid = 1'b1; req_write = 1'b1; req_mask = 4'b1111; req_addr = a; req_wdata = d;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rm_ready0: got %b expected 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (mem_write !== 1'b1 || mem_addr !== 16'd20) begin failures++; $display("[TB] FAIL rm_lane0: got %b@%h expected 1@0014", mem_write, mem_addr); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL rm_gate: got %b expected 0", mem_write); end
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[20] = d[15:0];
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_after: got ready=%b resp=%b expected 1/0", req_ready, resp_valid); end
        for (int c = 0; c < 8; c++) begin
            if (resp_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL rm_noresp: got resp_valid=1 expected 0"); end
        model_request(1'b0, 4'b1111, a, '0, exp_rd, exp_log, exp_cnt);
        do_request(1'b0, 4'b1111, a, '0, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
        checks++; if (tmo || rd !== exp_rd) begin failures++; $display("[TB] FAIL rm_contents: got %h expected %h", rd, exp_rd); end
    endtask

    task automatic test_back_to_back();
        logic [LANES*DATA_W-1:0] exp_q[$];
        int acc_cyc[3];
        int acc_vis[3];
        int n_acc = 0, n_resp = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 60 && n_resp < 3; c++) begin
            req_write = 1'($urandom); req_mask = LANES'($urandom);
            req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
            if (resp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL b2b_spurious: got response expected none"); end
                else begin
                    exp_rd = exp_q.pop_front();
                    if (resp_rdata !== exp_rd) begin failures++; $display("[TB] FAIL b2b_rdata: got %h expected %h", resp_rdata, exp_rd); end
                end
                n_resp++;
            end
            if (req_ready === 1'b1 && n_acc < 3) begin
                model_request(req_write, req_mask, req_addr, req_wdata, exp_rd, exp_log, exp_cnt);
                exp_q.push_back(exp_rd);
                acc_cyc[n_acc] = c;
                acc_vis[n_acc] = visited(req_mask);
                n_acc++;
            end
            step();
            if (n_acc == 3) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++; if (n_acc != 3 || n_resp != 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d accepts %0d responses expected 3/3", n_acc, n_resp); end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != acc_vis[i-1] + 2) begin
                failures++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d", acc_cyc[i] - acc_cyc[i-1], acc_vis[i-1] + 2);
            end
        end
    endtask

    task automatic test_random();
        logic w;
        logic [LANES-1:0] m;
        logic [LANES*ADDR_W-1:0] a;
        logic [LANES*DATA_W-1:0] d;
        for (int t = 0; t < 16; t++) begin
            w = 1'($urandom); m = LANES'($urandom);
            for (int i = 0; i < LANES; i++) begin
                a[i*ADDR_W +: ADDR_W] = {10'($urandom_range(0, 3)), 6'($urandom_range(40, 47))};
                d[i*DATA_W +: DATA_W] = 16'($urandom);
            end
            model_request(w, m, a, d, exp_rd, exp_log, exp_cnt);
            do_request(w, m, a, d, rd, lat, wlog, wcnt, rdy_a, pls_a, tmo);
            checks++; if (tmo || lat != visited(m)) begin failures++; $display("[TB] FAIL rnd_lat: got %0d expected %0d (t=%0d)", lat, visited(m), t); end
            checks++; if (rd !== exp_rd) begin failures++; $display("[TB] FAIL rnd_rdata: got %h expected %h (t=%0d)", rd, exp_rd, t); end
            checks++; if (wcnt != exp_cnt || wlog !== exp_log) begin failures++; $display("[TB] FAIL rnd_writes: got %0d %h expected %0d %h (t=%0d)", wcnt, wlog[159:0], exp_cnt, exp_log[159:0], t); end
            checks++; if (rdy_a !== 1'b1 || pls_a !== 1'b0) begin failures++; $display("[TB] FAIL rnd_after: got ready=%b resp=%b expected 1/0", rdy_a, pls_a); end
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_masked_load();
        test_same_addr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_serializer.md
Name: lsu_serializer

Overview:
- Load/store front end sitting directly upstream of the 64 x 16-bit data memory (async read, write on clk edge when MemWrite is high).
- Accepts one vector load or store request covering LANES lanes from the core.
- Serialises the request into one memory access per lane per cycle, collects load data, and returns it as one vector response.

Parameters:
- LANES, 4, number of lanes per request (>=1).
- DATA_W, 16, data word width; matches the memory word.
- ADDR_W, 16, address width per lane; passed to memory unmodified, and the memory uses only bits [5:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load (whole request).
- req_mask  in  LANES  per-lane enable; bit i enables lane i.
- req_addr  in  LANES*ADDR_W  lane i address at [i*ADDR_W +: ADDR_W].
- req_wdata  in  LANES*DATA_W  lane i store data at [i*DATA_W +: DATA_W].
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  LANES*DATA_W  load data per lane; held until next accept.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory WriteData.
- mem_rdata  in  DATA_W  from memory ReadData (combinational).

Behaviour:
- FSM states: IDLE, ACCESS, RESP; lane counter idx of width clog2(LANES).
- Reset values (after a reset edge):
  - state=IDLE, idx=0.
  - req_ready=1, resp_valid=0, resp_rdata=0.
  - mem_write=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: request is abandoned with no response. mem_write is combinationally forced to 0 while reset=1, so no write commits on a reset edge.
- IDLE:
  - req_ready=1.
  - Accept on the edge where req_valid&&req_ready. Latch write, mask, addr and wdata; clear resp_rdata to 0; idx=0; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - mem_addr = latched addr[idx]; mem_wdata = latched wdata[idx].
  - mem_write = write && mask[idx] && !reset.
  - On each edge, for a load with mask[idx]=1: resp_rdata lane idx <= mem_rdata.
  - If idx==LANES-1, go to RESP; else idx++.
  - Masked lanes still consume one cycle, perform no write, and return rdata 0.
- RESP: resp_valid=1 and req_ready=0 for exactly one cycle, then IDLE.
- Outside ACCESS: mem_write=0, mem_addr=0, mem_wdata=0.
- Latency: accept edge E; lane i is accessed in the cycle after edge E+i; resp_valid is high in the cycle after edge E+LANES.
  - Fixed LANES+2 cycles per request, from accept cycle to the next req_ready=1.
- Stores: the response pulse still occurs, and resp_rdata is all zero.
- Same address in several store lanes: lanes are written in ascending index order, so the highest enabled lane wins.
- Addresses are not range-checked. Aliasing modulo 64 is the memory's behaviour.
- Request inputs are ignored whenever req_ready=0.

Optional Feature:
- Macro: LSU_SKIP_MASKED_EN.
- Enabled:
  - ACCESS visits only lanes with mask=1, in ascending order; idx advances to the next set bit.
  - If the mask is all-zero, go IDLE->RESP directly.
  - Latency becomes popcount(mask)+2 cycles.
- Disabled: fixed LANES+2 latency as above.

Decomposition:
- Package lsu_pkg holds:
  - state encoding constants IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - default LANES/DATA_W/ADDR_W;
  - a clog2-based IDX_W constant.
- Sub-module lsu_lane_sel: combinational slice selector that returns lane idx address/data from the latched flat vectors, plus (with LSU_SKIP_MASKED_EN) the next-set-bit finder.

Test Plan:
- Reset, then idle: req_ready=1, resp_valid=0, mem_write=0, mem_addr=0 for 5 cycles.
- Store addr {3,2,1,0}, data {0xDDDD,0xCCCC,0xBBBB,0xAAAA}, mask 4'b1111:
  - mem_write high for 4 consecutive cycles at addr 0,1,2,3;
  - resp_valid in cycle 5 after accept;
  - then a load of the same addresses returns resp_rdata={0xDDDD,0xCCCC,0xBBBB,0xAAAA}.
- Load with mask 4'b0101 from addr {8,9,10,11} preloaded 0x1111..0x4444: resp_rdata={0,0x3333,0,0x1111}; no write pulse.
- Store to addr 5 in all lanes, data 1,2,3,4: a subsequent load of addr 5 returns 0x0004. With LSU_SKIP_MASKED_EN and mask 0: resp_valid 1 cycle after accept.
- Assert reset during the 2nd ACCESS cycle of a 4-lane store:
  - no mem_write on the reset edge;
  - only lane 0 is written;
  - no resp_valid;
  - req_ready=1 after the edge.
- Hold req_valid high with changing inputs for 3 back-to-back requests: each is accepted only when req_ready=1, spaced 6 cycles apart (LANES=4, feature off).
